uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencer for the UART_RX receiver. Generates its x16_BAUD tick from CLK via a programmable divisor.
//  Holds UART_RX in reset until the serial line has been idle (high), and re-syncs after a framing error.
//  Buffers received bytes in a FIFO behind a valid/ready consumer port; reports overrun and framing errors.
// PARAMETERS
//  P_DIV_W       16  width of div input
//  P_FIFO_DEPTH  8   byte FIFO depth; power of 2, >=2
//  P_IDLE_TICKS  16  consecutive x16 ticks with serial_in=1 required before arming UART_RX
// PORTS
//  CLK        in   1            system clock; single clock domain
//  reset      in   1            synchronous, active-high
//  enable     in   1            1 = receive path on
//  div        in   P_DIV_W      CLK cycles per x16 tick; 0 and 1 both mean a tick every cycle
//  serial_in  in   1            RX line monitor (same net as UART_RX.serial_in, pre-synchronised)
//  x16_BAUD   out  1            one-CLK tick pulse to UART_RX
//  rx_reset   out  1            reset to UART_RX, active-high
//  rx_Do      in   8            UART_RX.Do
//  rx_valid   in   1            UART_RX.valid; level or pulse, rising edge used
//  rx_error   in   1            UART_RX.error; rising edge used
//  m_data     out  8            FIFO head byte
//  m_valid    out  1            FIFO non-empty
//  m_ready    in   1            consumer accept
//  fifo_count out  clog2(D)+1   bytes held
//  overrun    out  1            sticky: byte dropped because FIFO full
//  frame_err  out  1            sticky: rx_error seen in S_RUN
//  clr        in   1            clears sticky flags (and stats); FIFO untouched
// BEHAVIOUR
//  Reset: state S_OFF, rx_reset=1, x16_BAUD=0, m_data=8'h00, m_valid=0, fifo_count=0, overrun=0, frame_err=0.
//  Tick gen: counter 0..div_l-1; x16_BAUD=1 for one CLK when counter==div_l-1; counter cleared and x16_BAUD=0 in S_OFF.
//   div_l is latched on S_OFF->S_SYNC; div changes mid-run are ignored until the next enable cycle.
//  FSM:
//   S_OFF : rx_reset=1, no ticks; enable=1 -> S_SYNC (latch div, idle_cnt=0).
//   S_SYNC: rx_reset=1, ticks run; on each tick idle_cnt++ if serial_in=1 else idle_cnt=0;
//           idle_cnt==P_IDLE_TICKS -> S_RUN; enable=0 -> S_OFF.
//   S_RUN : rx_reset=0; enable=0 -> S_OFF; rx_error rise -> frame_err=1, -> S_SYNC (idle_cnt=0).
//  rx_valid/rx_error edge detectors use registered previous values, cleared on reset and outside S_RUN.
//   Edges are honoured only in S_RUN.
//  Push: rx_valid rise in S_RUN writes rx_Do; if FIFO full and no pop in the same cycle, byte dropped, overrun=1.
//  Pop: m_valid & m_ready advances head. Push+pop in the same cycle (incl. full): both occur, count unchanged.
//  Latency: rx_valid rise at cycle N into empty FIFO -> m_valid=1, m_data=byte at N+1.
//  m_data holds last value when empty; pointers wrap modulo P_FIFO_DEPTH.
//  FIFO contents persist across S_OFF/S_SYNC; only reset empties it.
//  clr and a set event in the same cycle: set wins.
// CONFIGURATION
//  UART_RX_CTRL_STATS_EN defined: adds outputs err_cnt[7:0], ovr_cnt[7:0].
//   Counters saturate at 255, increment on each frame_err / overrun event (not just the first), reset to 0, cleared by clr.
//  Undefined: ports and counters absent; sticky flags unchanged.
// TESTING
//  1 reset, enable=1, div=2, serial_in=1 -> x16_BAUD every 2nd CLK; rx_reset falls after 16 ticks (32 CLKs+1).
//  2 serial_in=0 at tick 10 of sync -> idle count restarts; rx_reset falls only after 16 more high ticks.
//  3 UART_RX driven with frame 8'hA6 -> m_valid next cycle, m_data=8'hA6, fifo_count=1; m_ready=1 -> count 0.
//  4 m_ready=0, 9 bytes 8'h01..8'h09 -> count=8, overrun=1, head=8'h01, 8'h09 lost; clr -> overrun=0.
//  5 full FIFO, push and pop same cycle -> count stays 8, head advances to 8'h02, overrun stays 0.
//  6 rx_error pulse in S_RUN -> frame_err=1, rx_reset=1 next cycle, re-arm after 16 idle ticks; enable=0 -> S_OFF.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: x16 tick generator, idle-line arming FSM and byte FIFO for a UART_RX receiver.
// Define UART_RX_CTRL_STATS_EN to add saturating err_cnt/ovr_cnt event counters.
module uart_rx_ctrl #(
  parameter int P_DIV_W      = 16,
  parameter int P_FIFO_DEPTH = 8,
  parameter int P_IDLE_TICKS = 16
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [P_DIV_W-1:0]              div,
  input  logic                            serial_in,
  output logic                            x16_BAUD,
  output logic                            rx_reset,
  input  logic [7:0]                      rx_Do,
  input  logic                            rx_valid,
  input  logic                            rx_error,
  output logic [7:0]                      m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(P_FIFO_DEPTH):0]   fifo_count,
  output logic                            overrun,
  output logic                            frame_err,
`ifdef UART_RX_CTRL_STATS_EN
  output logic [7:0]                      err_cnt,
  output logic [7:0]                      ovr_cnt,
`endif
  input  logic                            clr
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(P_IDLE_TICKS + 1);

  typedef enum logic [1:0] {S_OFF, S_SYNC, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [P_DIV_W-1:0]   r_div_l, r_cnt, w_div_eff;
  logic                 w_tick;
  logic [IW-1:0]        r_idle;
  logic                 r_valid_d, r_error_d, w_valid_rise, w_error_rise;
  logic [7:0]           r_mem [P_FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0]        r_count;
  logic                 w_empty, w_full, w_pop, w_push, w_drop;
  logic [7:0]           r_m_data;
  logic                 r_overrun, r_frame_err;

  function automatic logic sticky_nxt(input logic cur, input logic set, input logic clear);
    return set | (cur & ~clear);
  endfunction

  // Divisors 0 and 1 both collapse to a tick on every cycle
  assign w_div_eff = (div < P_DIV_W'(2)) ? P_DIV_W'(1) : div;
  assign w_tick    = (r_state != S_OFF) && (r_cnt == r_div_l - P_DIV_W'(1));

  assign w_valid_rise = (r_state == S_RUN) && rx_valid && !r_valid_d;
  assign w_error_rise = (r_state == S_RUN) && rx_error && !r_error_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:   if (enable) w_state_nxt = S_SYNC;
      S_SYNC:  if (!enable) w_state_nxt = S_OFF;
               else if (r_idle == IW'(P_IDLE_TICKS)) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_OFF;
               else if (w_error_rise) w_state_nxt = S_SYNC;
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_OFF;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (reset)                          r_div_l <= P_DIV_W'(1);
    else if (r_state == S_OFF && enable) r_div_l <= w_div_eff;
  end

  always_ff @(posedge CLK) begin
    if (reset || r_state == S_OFF) r_cnt <= '0;
    else if (w_tick)               r_cnt <= '0;
    else                           r_cnt <= r_cnt + P_DIV_W'(1);
  end

  // Idle counter lives only in S_SYNC, so every entry into S_SYNC starts from zero
  always_ff @(posedge CLK) begin
    if (reset || r_state != S_SYNC) r_idle <= '0;
    else if (w_tick) begin
      if (!serial_in)                        r_idle <= '0;
      else if (r_idle != IW'(P_IDLE_TICKS))  r_idle <= r_idle + IW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || r_state != S_RUN) begin
      r_valid_d <= 1'b0;
      r_error_d <= 1'b0;
    end else begin
      r_valid_d <= rx_valid;
      r_error_d <= rx_error;
    end
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(P_FIFO_DEPTH));
  assign w_pop    = !w_empty && m_ready;
  assign w_push   = w_valid_rise && (!w_full || w_pop);
  assign w_drop   = w_valid_rise && w_full && !w_pop;
  assign w_rd_nxt = r_rd_ptr + AW'(1);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_Do;
  end

  // Registered head: when the FIFO drains, m_data keeps the last byte handed out
  always_ff @(posedge CLK) begin
    if (reset) r_m_data <= 8'h00;
    else if (w_pop) begin
      if (r_count > CW'(1)) r_m_data <= r_mem[w_rd_nxt];
      else if (w_push)      r_m_data <= rx_Do;
    end else if (w_empty && w_push) begin
      r_m_data <= rx_Do;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= sticky_nxt(r_overrun, w_drop, clr);
      r_frame_err <= sticky_nxt(r_frame_err, w_error_rise, clr);
    end
  end

`ifdef UART_RX_CTRL_STATS_EN
  logic [7:0] r_err_cnt, r_ovr_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_err_cnt <= 8'h00;
      r_ovr_cnt <= 8'h00;
    end else begin
      if (w_error_rise) r_err_cnt <= sat_inc8(r_err_cnt);
      else if (clr)     r_err_cnt <= 8'h00;
      if (w_drop)       r_ovr_cnt <= sat_inc8(r_ovr_cnt);
      else if (clr)     r_ovr_cnt <= 8'h00;
    end
  end

  assign err_cnt = r_err_cnt;
  assign ovr_cnt = r_ovr_cnt;
`endif

  assign x16_BAUD   = w_tick;
  assign rx_reset   = (r_state != S_RUN);
  assign m_data     = r_m_data;
  assign m_valid    = !w_empty;
  assign fifo_count = r_count;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule
